sensor_scan_ctrl: RTL

Sequencer that scans the four baggage-height sensors over one shared, time-multiplexed sensor port and captures each reading with a req/valid handshake. Once all four readings are captured it applies the team's zero-sensor height rule and presents one height result on a valid/ready output. It sits between the sensor bus and the drop-decision logic, replacing four parallel sensor buses with one.

---
 rtl/sensor_pkg.sv | 25 ++
 rtl/height_calc.sv | 61 ++++++
 rtl/sensor_scan_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sensor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sensor_pkg
// Description : Shared types and constants for the baggage-height sensor
//               scanner (state encoding, sensor index, default widths).
// Revision    : 1.0 - initial release
// ============================================================================
package sensor_pkg;

    localparam int SENSOR_W_DEFAULT = 8;
    localparam int NUM_SENSORS      = 4;

    // Sequencer states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        CALC = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Index of one of the four sensors on the shared port
    typedef logic [1:0] sensor_idx_t;

endpackage : sensor_pkg
`default_nettype wire

// File: rtl/height_calc.sv
`default_nettype none
// ============================================================================
// Module      : height_calc
// Description : Combinational zero-sensor height rule. A zero in pair
//               {s1,s3} selects the {s2,s4} average, else a zero in pair
//               {s2,s4} selects the {s1,s3} average, else the rounded mean
//               of all four. fault flags a zero present in both pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module height_calc
    import sensor_pkg::*;
#(
    parameter int SENSOR_W = SENSOR_W_DEFAULT
)(
    input  logic [SENSOR_W-1:0] s1,
    input  logic [SENSOR_W-1:0] s2,
    input  logic [SENSOR_W-1:0] s3,
    input  logic [SENSOR_W-1:0] s4,
    output logic [SENSOR_W-1:0] height,
    output logic                fault
);

    logic              w_zero_13;
    logic              w_zero_24;
    logic [SENSOR_W:0]   w_sum_13;
    logic [SENSOR_W:0]   w_sum_24;
    logic [SENSOR_W:0]   w_avg_13;
    logic [SENSOR_W:0]   w_avg_24;
    logic [SENSOR_W+1:0] w_sum_all;
    logic [SENSOR_W+1:0] w_avg_all;

    assign w_zero_13 = (s1 == '0) || (s3 == '0);
    assign w_zero_24 = (s2 == '0) || (s4 == '0);

    // Pair sums keep one extra bit and the full sum two, so nothing truncates
    // before the rounding shift.
    assign w_sum_13  = {1'b0, s1} + {1'b0, s3};
    assign w_sum_24  = {1'b0, s2} + {1'b0, s4};
    assign w_sum_all = {1'b0, w_sum_13} + {1'b0, w_sum_24};

    // +1 / +2 round to nearest; the rounded sums cannot carry out of the
    // widened operands because the largest operands are all-ones.
    assign w_avg_13  = (w_sum_13 + (SENSOR_W+1)'(1)) >> 1;
    assign w_avg_24  = (w_sum_24 + (SENSOR_W+1)'(1)) >> 1;
    assign w_avg_all = (w_sum_all + (SENSOR_W+2)'(2)) >> 2;

    // Priority selection of the height source; fault is informational only
    always_comb begin
        height = '0;
        if (w_zero_13) begin
            height = w_avg_24[SENSOR_W-1:0];
        end else if (w_zero_24) begin
            height = w_avg_13[SENSOR_W-1:0];
        end else begin
            height = w_avg_all[SENSOR_W-1:0];
        end
        fault = w_zero_13 && w_zero_24;
    end

endmodule : height_calc
`default_nettype wire

// File: rtl/sensor_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sensor_scan_ctrl
// Description : Scans four height sensors over one shared req/valid port,
//               captures the readings into slot registers, computes the
//               height with height_calc and presents it on valid/ready.
//               Optional feature macro: SENSOR_TIMEOUT_EN (per-sensor wait
//               limit of TIMEOUT_CYCLES; a silent sensor reads as zero).
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_scan_ctrl
    import sensor_pkg::*;
#(
    parameter int SENSOR_W       = SENSOR_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [1:0]          sensor_sel,
    output logic                sensor_req,
    input  logic [SENSOR_W-1:0] sensor_data,
    input  logic                sensor_valid,
    output logic                busy,
    output logic [SENSOR_W-1:0] height,
    output logic                fault,
    output logic                timeout,
    output logic                out_valid,
    input  logic                out_ready
);

    state_t               r_state;
    state_t               w_state_nxt;
    sensor_idx_t          r_index;
    logic [SENSOR_W-1:0]  r_slot [NUM_SENSORS];
    logic [SENSOR_W-1:0]  r_height;
    logic                 r_fault;
    logic [SENSOR_W-1:0]  w_calc_height;
    logic                 w_calc_fault;
    logic                 w_capture;
    logic                 w_tmo;
    logic                 w_start_acc;

    assign w_start_acc = (r_state == IDLE) && start;

`ifdef SENSOR_TIMEOUT_EN
    localparam int c_WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_WAIT_W-1:0]  r_wait;
    logic                 r_timeout;

    // The wait limit is reached on the last of TIMEOUT_CYCLES silent cycles
    assign w_tmo = (r_state == SCAN) && !sensor_valid
                   && (r_wait == c_WAIT_W'(TIMEOUT_CYCLES - 1));

    // Per-sensor wait counter, restarted whenever a new request begins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= '0;
        end else if ((r_state != SCAN) || w_capture) begin
            r_wait <= '0;
        end else begin
            r_wait <= r_wait + c_WAIT_W'(1);
        end
    end

    // Sticky timeout flag for the current scan, cleared by an accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else if (w_start_acc) begin
            r_timeout <= 1'b0;
        end else if (w_tmo) begin
            r_timeout <= 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_tmo   = 1'b0;
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and capture strobe
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (sensor_valid || w_tmo) begin
                    w_capture = 1'b1;
                    if (r_index == 2'd3) begin
                        w_state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                w_state_nxt = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Sensor index and slot capture; a timed-out sensor is stored as zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_index <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            if (w_start_acc) begin
                r_index <= '0;
            end else if (w_capture) begin
                r_slot[r_index] <= w_tmo ? '0 : sensor_data;
                r_index         <= r_index + 2'd1;
            end
        end
    end

    height_calc #(
        .SENSOR_W (SENSOR_W)
    ) u_height_calc (
        .s1     (r_slot[0]),
        .s2     (r_slot[1]),
        .s3     (r_slot[2]),
        .s4     (r_slot[3]),
        .height (w_calc_height),
        .fault  (w_calc_fault)
    );

    // Result register, loaded once per scan so it stays stable through HOLD
    always_ff @(posedge clk) begin
        if (rst) begin
            r_height <= '0;
            r_fault  <= 1'b0;
        end else if (r_state == CALC) begin
            r_height <= w_calc_height;
            r_fault  <= w_calc_fault;
        end
    end

    assign sensor_req = (r_state == SCAN);
    assign sensor_sel = r_index;
    assign busy       = (r_state != IDLE);
    assign out_valid  = (r_state == HOLD);
    assign height     = r_height;
    assign fault      = r_fault;

endmodule : sensor_scan_ctrl
`default_nettype wire
